// File: rtl/wb_write_arbiter_if.sv
// Signal bundle between the writeback arbiter and its producers/consumers:
// ALU results, long-latency results, issue/decode scoreboard traffic and the register-file write port.
interface wb_write_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  alu_valid;
  logic [4:0]            alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  ldu_valid;
  logic                  ldu_ready;
  logic [4:0]            ldu_rd;
  logic [DATA_WIDTH-1:0] ldu_data;

  logic                  issue_valid;
  logic [4:0]            issue_rd;

  logic [4:0]            rs1_addr;
  logic [4:0]            rs2_addr;
  logic                  rs1_busy;
  logic                  rs2_busy;

  logic                  regWrite;
  logic [4:0]            writeAddr;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  idle;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ldu_valid, ldu_rd, ldu_data,
    output ldu_ready,
    input  issue_valid, issue_rd,
    input  rs1_addr, rs2_addr,
    output rs1_busy, rs2_busy,
    output regWrite, writeAddr, writeData, idle
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ldu_valid, ldu_rd, ldu_data,
    input  ldu_ready,
    output issue_valid, issue_rd,
    output rs1_addr, rs2_addr,
    input  rs1_busy, rs2_busy,
    input  regWrite, writeAddr, writeData, idle
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Merges ALU and long-latency results onto one registered register-file write port.
// Also tracks destinations whose long-latency write is still outstanding.
module wb_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  wb_write_arbiter_if.slave  bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [4:0]            r_fifo_rd   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [31:0]           r_pending;
  logic                  r_reg_write;
  logic [4:0]            r_write_addr;
  logic [DATA_WIDTH-1:0] r_write_data;

  logic                  w_ldu_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_alu_win;
  logic [4:0]            w_head_rd;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [31:0]           w_pending_nxt;

  // Ready looks only at the registered count: a same-cycle pop gives no credit.
  assign w_ldu_ready = (r_count < CW'(FIFO_DEPTH));
  assign w_alu_win   = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign w_push      = bus.ldu_valid && w_ldu_ready && (bus.ldu_rd != 5'd0);
  assign w_pop       = !w_alu_win && (r_count != '0);
  assign w_head_rd   = r_fifo_rd[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // Clear first, then set, so a re-issue of the register being retired stays pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop)
      w_pending_nxt[w_head_rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != 5'd0))
      w_pending_nxt[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_fifo_rd[r_wr_ptr]   <= bus.ldu_rd;
      r_fifo_data[r_wr_ptr] <= bus.ldu_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_pending    <= '0;
      r_reg_write  <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_alu_win) begin
        r_reg_write  <= 1'b1;
        r_write_addr <= bus.alu_rd;
        r_write_data <= bus.alu_data;
      end else if (w_pop) begin
        r_reg_write  <= 1'b1;
        r_write_addr <= w_head_rd;
        r_write_data <= w_head_data;
      end else begin
        r_reg_write  <= 1'b0;
      end
    end
  end

  assign bus.ldu_ready = w_ldu_ready;
  assign bus.rs1_busy  = r_pending[bus.rs1_addr];
  assign bus.rs2_busy  = r_pending[bus.rs2_addr];
  assign bus.regWrite  = r_reg_write;
  assign bus.writeAddr = r_write_addr;
  assign bus.writeData = r_write_data;
  assign bus.idle      = (r_count == '0) && (r_pending == '0);
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_write_arbiter;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  wb_write_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  wb_write_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: ordered queue of buffered results and a pending-register set.
  logic [4:0]    mq_rd   [$];
  logic [DW-1:0] mq_data [$];
  bit   [31:0]   m_pend;
  logic          m_we;
  logic [4:0]    m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_accepted;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = 5'd0;
    bus.alu_data    = '0;
    bus.ldu_valid   = 1'b0;
    bus.ldu_rd      = 5'd0;
    bus.ldu_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
  endtask

  task automatic model_reset();
    mq_rd.delete();
    mq_data.delete();
    m_pend  = '0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model, check registered outputs.
  task automatic cycle();
    logic exp_ready;
    logic [4:0] head;
    @(negedge clk);
    exp_ready = (mq_rd.size() < DEPTH);
    if (!rst) begin
      chk("ldu_ready", bus.ldu_ready, exp_ready);
      chk("rs1_busy", bus.rs1_busy, m_pend[bus.rs1_addr]);
      chk("rs2_busy", bus.rs2_busy, m_pend[bus.rs2_addr]);
      chk("idle", bus.idle, (mq_rd.size() == 0) && (m_pend == 0));
    end
    m_accepted = bus.ldu_valid && exp_ready && !rst;
    if (rst) begin
      model_reset();
    end else begin
      if (bus.alu_valid && bus.alu_rd != 0) begin
        m_we = 1'b1; m_addr = bus.alu_rd; m_wdata = bus.alu_data;
      end else if (mq_rd.size() != 0) begin
        head = mq_rd.pop_front();
        m_we = 1'b1; m_addr = head; m_wdata = mq_data.pop_front();
        m_pend[head] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (m_accepted && bus.ldu_rd != 0) begin
        mq_rd.push_back(bus.ldu_rd);
        mq_data.push_back(bus.ldu_data);
      end
      if (bus.issue_valid && bus.issue_rd != 0)
        m_pend[bus.issue_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("regWrite", bus.regWrite, m_we);
    chk("writeAddr", bus.writeAddr, m_addr);
    chk("writeData", bus.writeData, m_wdata);
  endtask

  initial begin
    logic [4:0] lrd [3];
    int lidx;
    set_idle();
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_regWrite", bus.regWrite, 1'b0);
    chk("rst_ready", bus.ldu_ready, 1'b1);
    chk("rst_idle", bus.idle, 1'b1);
    repeat (3) cycle();

    // ALU only, then ALU with rd=0
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h0000_00AA;
    cycle();
    chk("alu_addr", bus.writeAddr, 5'd5);
    chk("alu_data", bus.writeData, 32'hAA);
    bus.alu_rd = 5'd0;
    cycle();
    chk("alu_r0_we", bus.regWrite, 1'b0);
    set_idle();

    // Load path with scoreboard
    bus.rs1_addr = 5'd7;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    cycle();
    set_idle();
    chk("busy_r7", bus.rs1_busy, 1'b1);
    repeat (2) cycle();
    bus.ldu_valid = 1'b1; bus.ldu_rd = 5'd7; bus.ldu_data = 32'hDEAD_BEEF;
    cycle();
    set_idle();
    cycle();
    chk("load_addr", bus.writeAddr, 5'd7);
    chk("load_data", bus.writeData, 32'hDEAD_BEEF);
    cycle();

    // Contention: ALU owns the port for 4 cycles, three long-latency results offered
    lrd[0] = 5'd1; lrd[1] = 5'd2; lrd[2] = 5'd3;
    lidx = 0;
    for (int c = 0; c < 10; c++) begin
      bus.alu_valid = (c < 4);
      bus.alu_rd    = (c < 4) ? 5'(10 + c) : 5'd0;
      bus.alu_data  = 32'h1000 + c;
      bus.ldu_valid = (lidx < 3);
      bus.ldu_rd    = (lidx < 3) ? lrd[lidx] : 5'd0;
      bus.ldu_data  = 32'hA000 + lidx;
      cycle();
      if (m_accepted) lidx++;
    end
    chk("contention_all_accepted", 32'(lidx), 32'd3);
    set_idle();

    // Simultaneous set/clear on r9
    bus.rs2_addr = 5'd9;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    cycle();
    set_idle();
    bus.ldu_valid = 1'b1; bus.ldu_rd = 5'd9; bus.ldu_data = 32'h99;
    cycle();
    set_idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    cycle();
    set_idle();
    chk("setclr_busy", bus.rs2_busy, 1'b1);
    bus.ldu_valid = 1'b1; bus.ldu_rd = 5'd9; bus.ldu_data = 32'h9A;
    cycle();
    set_idle();
    repeat (2) cycle();

    // Reset mid-operation: two buffered entries, pending {4,6}
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd20;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    bus.ldu_valid = 1'b1; bus.ldu_rd = 5'd4; bus.ldu_data = 32'h44;
    cycle();
    bus.issue_rd = 5'd6;
    bus.ldu_rd = 5'd6; bus.ldu_data = 32'h66;
    cycle();
    set_idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_we", bus.regWrite, 1'b0);
    chk("midrst_idle", bus.idle, 1'b1);
    repeat (4) cycle();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst             = ($urandom_range(0, 99) == 0);
      bus.alu_valid   = ($urandom_range(0, 1) == 1);
      bus.alu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.alu_data    = $urandom;
      bus.ldu_valid   = ($urandom_range(0, 1) == 1);
      bus.ldu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.ldu_data    = $urandom;
      bus.issue_valid = ($urandom_range(0, 2) == 0);
      bus.issue_rd    = 5'($urandom);
      bus.rs1_addr    = 5'($urandom);
      bus.rs2_addr    = 5'($urandom);
      cycle();
    end
    rst = 1'b0;
    set_idle();
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
